mem_access: RTL

- MEM-stage load/store unit. Sits between the execute stage and the data memory.
- Consumes the execute-stage outputs: ALU op, effective memory address, store data, ALU result, destination register and write enable.
- Word lw/sw accesses go through a req/ack handshake to a variable-latency data memory; upstream is stalled while an access is outstanding.
- Every retired instruction is presented as a registered one-cycle packet to writeback.

---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mem_timeout_cnt.sv | 38 +++
 rtl/mem_access.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and widths for the MEM-stage load/store unit.
// Holds the ALU op codes, the access FSM states and the word/register-index types.
package mem_access_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [4:0]        alu_op_t;

    localparam alu_op_t OP_ADD  = 5'b00000;
    localparam alu_op_t OP_SUB  = 5'b00001;
    localparam alu_op_t OP_AND  = 5'b00010;
    localparam alu_op_t OP_OR   = 5'b00011;
    localparam alu_op_t OP_XOR  = 5'b00100;
    localparam alu_op_t OP_SLL  = 5'b00101;
    localparam alu_op_t OP_SRL  = 5'b00110;
    localparam alu_op_t OP_SRA  = 5'b00111;
    localparam alu_op_t OP_SLT  = 5'b01000;
    localparam alu_op_t OP_SLTU = 5'b01001;
    localparam alu_op_t OP_LUI  = 5'b01010;
    localparam alu_op_t OP_JAL  = 5'b01100;
    localparam alu_op_t OP_JALR = 5'b01101;
    localparam alu_op_t OP_LW   = 5'b10100;
    localparam alu_op_t OP_SW   = 5'b10101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    function automatic logic is_mem_op(input alu_op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access watchdog: counts ACCESS cycles without completion and flags the terminal count.
// A TIMEOUT of 0 keeps the terminal count permanently low.
module mem_timeout_cnt #(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: word lw/sw over a req/ack memory port, everything else
// passed straight through; every retirement leaves as a registered one-cycle packet.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_i,
    input  logic [4:0]           ALUop_i,
    input  logic [WORD_W-1:0]    MemAddr_i,
    input  logic [WORD_W-1:0]    StoreData_i,
    input  logic [WORD_W-1:0]    WriteData_i,
    input  logic [REG_W-1:0]     WriteDataNum_i,
    input  logic                 WriteReg_i,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [WORD_W-1:0]    mem_addr_o,
    output logic [WORD_W-1:0]    mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [WORD_W-1:0]    mem_rdata_i,
    output logic                 wb_valid_o,
    output logic                 WriteReg_o,
    output logic [REG_W-1:0]     WriteDataNum_o,
    output logic [WORD_W-1:0]    WriteData_o,
    output logic                 misalign_o,
    output logic                 timeout_o
);

    state_e   state_q, state_d;
    logic     mem_req_q, mem_req_d;
    logic     mem_we_q, mem_we_d;
    word_t    mem_addr_q, mem_addr_d;
    word_t    mem_wdata_q, mem_wdata_d;
    logic     wb_valid_q, wb_valid_d;
    logic     wreg_q, wreg_d;
    reg_idx_t wnum_q, wnum_d;
    word_t    wdata_q, wdata_d;
    logic     misalign_q, misalign_d;
    logic     timeout_q, timeout_d;
    reg_idx_t rd_q, rd_d;
    logic     rd_we_q, rd_we_d;
    logic     is_sw_q, is_sw_d;

    logic     cnt_clr;
    logic     cnt_en;
    logic     cnt_tc;

    mem_timeout_cnt #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        wreg_d      = wreg_q;
        wnum_d      = wnum_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        is_sw_d     = is_sw_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i) begin
                    if (!is_mem_op(ALUop_i)) begin
                        wb_valid_d = 1'b1;
                        wdata_d    = WriteData_i;
                        wnum_d     = WriteDataNum_i;
                        wreg_d     = WriteReg_i && (WriteDataNum_i != '0);
                    end else if (MemAddr_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        wb_valid_d = 1'b1;
                        wreg_d     = 1'b0;
                        wdata_d    = '0;
                        wnum_d     = WriteDataNum_i;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_clr     = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (ALUop_i == OP_SW);
                        mem_addr_d  = {MemAddr_i[WORD_W-1:2], 2'b00};
                        mem_wdata_d = (ALUop_i == OP_SW) ? StoreData_i : '0;
                        rd_d        = WriteDataNum_i;
                        rd_we_d     = WriteReg_i;
                        is_sw_d     = (ALUop_i == OP_SW);
                    end
                end
            end
            ST_ACCESS: begin
                // Ack takes priority over a timeout landing on the same cycle.
                if (mem_ack_i) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wnum_d     = rd_q;
                    if (is_sw_q) begin
                        wreg_d  = 1'b0;
                        wdata_d = '0;
                    end else begin
                        wreg_d  = rd_we_q && (rd_q != '0);
                        wdata_d = mem_rdata_i;
                    end
                end else if (cnt_tc) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    timeout_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wreg_d     = 1'b0;
                    wnum_d     = rd_q;
                    wdata_d    = '0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wreg_q      <= 1'b0;
            wnum_q      <= '0;
            wdata_q     <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            is_sw_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wreg_q      <= wreg_d;
            wnum_q      <= wnum_d;
            wdata_q     <= wdata_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            is_sw_q     <= is_sw_d;
        end
    end

    assign stall_o        = (state_q == ST_ACCESS);
    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign WriteReg_o     = wreg_q;
    assign WriteDataNum_o = wnum_q;
    assign WriteData_o    = wdata_q;
    assign misalign_o     = misalign_q;
    assign timeout_o      = timeout_q;

endmodule
